// File: rtl/axi_read_slave_pkg.sv
// Shared types and widths for the AXI read slave: burst/resp encodings, FSM states
// and the bus widths that follow from the data width.
package axi_read_slave_pkg;

    localparam int WIDTH   = 32;
    localparam int SIZE    = 3;
    localparam int ID_W    = WIDTH / 8;
    localparam int LEN_W   = WIDTH / 8;
    localparam int BURST_W = SIZE - 1;
    localparam int RESP_W  = SIZE - 1;
    localparam int LANES   = WIDTH / 8;
    localparam int LANE_W  = $clog2(LANES);

    typedef enum logic [BURST_W-1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    typedef enum logic [RESP_W-1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi_read_slave_if.sv
// AR/R channel bundle between a read master and the read slave.
interface axi_read_slave_if;
    import axi_read_slave_pkg::*;

    logic               arvalid;
    logic               arready;
    logic [ID_W-1:0]    arid;
    logic [WIDTH-1:0]   araddr;
    logic [LEN_W-1:0]   arlen;
    logic [SIZE-1:0]    arsize;
    logic [BURST_W-1:0] arburst;

    logic               rvalid;
    logic               rready;
    logic [ID_W-1:0]    rid;
    logic [WIDTH-1:0]   rdata;
    logic [RESP_W-1:0]  rresp;
    logic               rlast;

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

endinterface

// File: rtl/axi_read_slave_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; reserved bursts
// step like INCR. Shared with the write slave.
module axi_read_slave_addr_gen
    import axi_read_slave_pkg::*;
(
    input  logic [WIDTH-1:0] addr,
    input  logic [LEN_W-1:0] len,
    input  logic [SIZE-1:0]  size,
    input  burst_e           burst,
    output logic [WIDTH-1:0] next_addr
);

    logic [WIDTH-1:0] beat_bytes;
    logic [WIDTH-1:0] aligned;
    logic [WIDTH-1:0] incr_addr;
    logic [WIDTH-1:0] wrap_bytes;
    logic [WIDTH-1:0] wrap_base;

    always_comb begin
        beat_bytes = WIDTH'(1) << size;
        aligned    = addr & ~(beat_bytes - WIDTH'(1));
        incr_addr  = aligned + beat_bytes;
        wrap_bytes = (WIDTH'(len) + WIDTH'(1)) << size;
        wrap_base  = aligned & ~(wrap_bytes - WIDTH'(1));
        case (burst)
            BURST_FIXED: next_addr = addr;
            // leaving the wrap window puts us back at its base
            BURST_WRAP:  next_addr = (incr_addr == wrap_base + wrap_bytes) ? wrap_base : incr_addr;
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_read_slave.sv
// AXI3 read-channel responder: one burst per AR handshake, beats fetched from a
// combinational byte memory. Optional 4KB-crossing check under AXI_RD_4K_CHECK_EN.
//
// state    | meaning
// RD_IDLE  | arready high, waiting for an AR handshake
// RD_BURST | rvalid high, presenting beats until the rlast handshake
module axi_read_slave
    import axi_read_slave_pkg::*;
#(
    parameter int MEM_BYTES = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [MEM_BYTES-1:0][7:0] slave_mem,
    axi_read_slave_if.slave           bus
);

    localparam int IDX_W = $clog2(MEM_BYTES);

    rd_state_e        state_q, state_d;
    logic             arready_q, arready_d;
    logic             rvalid_q, rvalid_d;
    logic             rlast_q, rlast_d;
    logic [ID_W-1:0]  rid_q, rid_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    resp_e            rresp_q, rresp_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [SIZE-1:0]  size_q, size_d;
    burst_e           burst_q, burst_d;
    logic             err_q, err_d;

    logic             ar_fire;
    logic             r_fire;
    burst_e           ar_burst;
    logic             ar_err;
    logic [WIDTH-1:0] next_addr;
    logic [WIDTH-1:0] fetch_addr;
    logic [SIZE-1:0]  fetch_size;
    logic             fetch_err;
    logic             fetch_dec;
    logic [WIDTH-1:0] fetch_data;
    resp_e            fetch_resp;
    logic [LANE_W-1:0] blk_mask;
    logic [WIDTH-1:0] lane_addr;

    axi_read_slave_addr_gen u_addr_gen (
        .addr      (addr_q),
        .len       (len_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    assign ar_fire  = bus.arvalid & arready_q;
    assign r_fire   = rvalid_q & bus.rready;
    assign ar_burst = burst_e'(bus.arburst);

`ifdef AXI_RD_4K_CHECK_EN
    logic [WIDTH-1:0] ar_span_end;
`endif

    always_comb begin
        ar_err = (bus.arsize > SIZE'(2)) || (ar_burst == BURST_RSVD) ||
                 ((ar_burst == BURST_WRAP) &&
                  !((bus.arlen == LEN_W'(1)) || (bus.arlen == LEN_W'(3)) ||
                    (bus.arlen == LEN_W'(7)) || (bus.arlen == LEN_W'(15))));
`ifdef AXI_RD_4K_CHECK_EN
        ar_span_end = (bus.araddr & ~((WIDTH'(1) << bus.arsize) - WIDTH'(1))) +
                      ((WIDTH'(bus.arlen) + WIDTH'(1)) << bus.arsize) - WIDTH'(1);
        if (((ar_burst == BURST_INCR) || (ar_burst == BURST_RSVD)) &&
            (ar_span_end[WIDTH-1:12] != bus.araddr[WIDTH-1:12]))
            ar_err = 1'b1;
`endif
    end

    // In IDLE the beat being loaded is beat 0 of the incoming AR; otherwise the next beat.
    always_comb begin
        fetch_addr = (state_q == RD_IDLE) ? bus.araddr : next_addr;
        fetch_size = (state_q == RD_IDLE) ? bus.arsize : size_q;
        fetch_err  = (state_q == RD_IDLE) ? ar_err     : err_q;
        case (fetch_size)
            SIZE'(0): blk_mask = 2'b11;
            SIZE'(1): blk_mask = 2'b10;
            default:  blk_mask = 2'b00;
        endcase
        fetch_data = '0;
        fetch_dec  = 1'b0;
        lane_addr  = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_addr = {fetch_addr[WIDTH-1:LANE_W], LANE_W'(l)};
            if (((LANE_W'(l) & blk_mask) == (fetch_addr[LANE_W-1:0] & blk_mask)) &&
                (LANE_W'(l) >= fetch_addr[LANE_W-1:0])) begin
                if (lane_addr >= WIDTH'(MEM_BYTES))
                    fetch_dec = 1'b1;
                else
                    fetch_data[8*l +: 8] = slave_mem[lane_addr[IDX_W-1:0]];
            end
        end
        fetch_resp = RESP_OKAY;
        if (fetch_err) begin
            fetch_resp = RESP_SLVERR;
            fetch_data = '0;
        end else if (fetch_dec) begin
            fetch_resp = RESP_DECERR;
            fetch_data = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        size_d    = size_q;
        burst_d   = burst_q;
        err_d     = err_q;
        case (state_q)
            RD_IDLE: begin
                arready_d = 1'b1;
                if (ar_fire) begin
                    state_d   = RD_BURST;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rid_d     = bus.arid;
                    addr_d    = bus.araddr;
                    len_d     = bus.arlen;
                    size_d    = bus.arsize;
                    burst_d   = ar_burst;
                    err_d     = ar_err;
                    beat_d    = '0;
                    rdata_d   = fetch_data;
                    rresp_d   = fetch_resp;
                    rlast_d   = (bus.arlen == '0);
                end
            end
            RD_BURST: begin
                if (r_fire) begin
                    if (rlast_q) begin
                        state_d   = RD_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                    end else begin
                        beat_d  = beat_q + LEN_W'(1);
                        addr_d  = next_addr;
                        rdata_d = fetch_data;
                        rresp_d = fetch_resp;
                        rlast_d = (beat_d == len_q);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RD_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            size_q    <= '0;
            burst_q   <= BURST_FIXED;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
        end
    end

    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rlast   = rlast_q;
    assign bus.rid     = rid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

endmodule

// File: tb/tb_axi_read_slave.sv
// Directed bench for axi_read_slave: expected beats are queued per AR, a negedge
// monitor pops and compares each R handshake.
module tb_axi_read_slave;
    import axi_read_slave_pkg::*;

    localparam int MEM_BYTES = 4096;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [MEM_BYTES-1:0][7:0] slave_mem;

    axi_read_slave_if bus ();

    axi_read_slave #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk       (clk),
        .reset     (reset),
        .slave_mem (slave_mem),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic exp_beat(input logic [3:0] id, input logic [31:0] data,
                            input logic [1:0] resp, input logic last);
        beat_t b;
        b.id = id; b.data = data; b.resp = resp; b.last = last;
        exp_q.push_back(b);
    endtask

    // Called #1 after a posedge; returns #1 after the AR handshake edge.
    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input burst_e burst);
        bit done = 1'b0;
        bus.arid    = id;
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = burst;
        bus.arvalid = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (bus.arready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.arvalid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ar_handshake_timeout actual=no_arready required=arready");
        end else begin
            chk("first_beat_latency", bus.rvalid, 1'b1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d_beats_left required=0", exp_q.size());
            exp_q.delete();
        end else begin
            chk("idle_rvalid", bus.rvalid, 1'b0);
            chk("idle_arready", bus.arready, 1'b1);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!reset && bus.rvalid && bus.rready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual=rdata_0x%0h required=no_beat", bus.rdata);
            end else begin
                e = exp_q.pop_front();
                chk("rid", bus.rid, e.id);
                chk("rdata", bus.rdata, e.data);
                chk("rresp", bus.rresp, e.resp);
                chk("rlast", bus.rlast, e.last);
            end
        end
    end

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) slave_mem[i] = 8'(i);
        bus.arvalid = 1'b0;
        bus.arid    = '0;
        bus.araddr  = '0;
        bus.arlen   = '0;
        bus.arsize  = '0;
        bus.arburst = '0;
        bus.rready  = 1'b1;
        reset       = 1'b1;

        #12;
        chk("rst_arready", bus.arready, 1'b0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_rlast", bus.rlast, 1'b0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_rid", bus.rid, 4'h0);
        chk("rst_rresp", bus.rresp, 2'd0);
        #10 reset = 1'b0;
        @(posedge clk); #1;
        chk("arready_after_reset", bus.arready, 1'b1);

        // INCR word burst
        exp_beat(4'd5, 32'h03020100, 2'd0, 1'b0);
        exp_beat(4'd5, 32'h07060504, 2'd0, 1'b0);
        exp_beat(4'd5, 32'h0B0A0908, 2'd0, 1'b0);
        exp_beat(4'd5, 32'h0F0E0D0C, 2'd0, 1'b1);
        do_ar(4'd5, 32'h100, 4'd3, 3'd2, BURST_INCR);
        drain();

        // WRAP 16-byte window starting mid-window
        exp_beat(4'd2, 32'h0B0A0908, 2'd0, 1'b0);
        exp_beat(4'd2, 32'h0F0E0D0C, 2'd0, 1'b0);
        exp_beat(4'd2, 32'h03020100, 2'd0, 1'b0);
        exp_beat(4'd2, 32'h07060504, 2'd0, 1'b1);
        do_ar(4'd2, 32'h108, 4'd3, 3'd2, BURST_WRAP);
        drain();

        // FIXED byte beats on lane 3
        exp_beat(4'd7, 32'h03000000, 2'd0, 1'b0);
        exp_beat(4'd7, 32'h03000000, 2'd0, 1'b1);
        do_ar(4'd7, 32'h203, 4'd1, 3'd0, BURST_FIXED);
        drain();

        // unaligned halfword INCR
        exp_beat(4'd8, 32'h00000100, 2'd0, 1'b0);
        exp_beat(4'd8, 32'h03020000, 2'd0, 1'b0);
        exp_beat(4'd8, 32'h00000504, 2'd0, 1'b1);
        do_ar(4'd8, 32'h101, 4'd2, 3'd1, BURST_INCR);
        drain();

        // backpressure on beat 2, with a competing AR that must be ignored
        exp_beat(4'd9, 32'h43424140, 2'd0, 1'b0);
        exp_beat(4'd9, 32'h47464544, 2'd0, 1'b0);
        exp_beat(4'd9, 32'h4B4A4948, 2'd0, 1'b0);
        exp_beat(4'd9, 32'h4F4E4D4C, 2'd0, 1'b1);
        do_ar(4'd9, 32'h040, 4'd3, 3'd2, BURST_INCR);
        @(posedge clk); #1;
        bus.rready  = 1'b0;
        bus.arvalid = 1'b1;
        bus.araddr  = 32'h300;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("stall_rvalid", bus.rvalid, 1'b1);
            chk("stall_rdata", bus.rdata, 32'h47464544);
            chk("stall_rlast", bus.rlast, 1'b0);
            chk("stall_rid", bus.rid, 4'd9);
            chk("stall_arready", bus.arready, 1'b0);
        end
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        drain();

        // SLVERR cases: oversize, reserved burst, bad WRAP length
        exp_beat(4'd1, 32'h0, 2'd2, 1'b0);
        exp_beat(4'd1, 32'h0, 2'd2, 1'b1);
        do_ar(4'd1, 32'h000, 4'd1, 3'd3, BURST_INCR);
        drain();
        exp_beat(4'd10, 32'h0, 2'd2, 1'b0);
        exp_beat(4'd10, 32'h0, 2'd2, 1'b1);
        do_ar(4'd10, 32'h100, 4'd1, 3'd2, BURST_RSVD);
        drain();
        exp_beat(4'd11, 32'h0, 2'd2, 1'b0);
        exp_beat(4'd11, 32'h0, 2'd2, 1'b0);
        exp_beat(4'd11, 32'h0, 2'd2, 1'b1);
        do_ar(4'd11, 32'h100, 4'd2, 3'd2, BURST_WRAP);
        drain();

        // DECERR single beat past the end of memory
        exp_beat(4'd3, 32'h0, 2'd3, 1'b1);
        do_ar(4'd3, 32'h1000, 4'd0, 3'd2, BURST_INCR);
        drain();

        // burst running off the end of memory across the 4KB line
`ifdef AXI_RD_4K_CHECK_EN
        exp_beat(4'd4, 32'h0, 2'd2, 1'b0);
        exp_beat(4'd4, 32'h0, 2'd2, 1'b0);
        exp_beat(4'd4, 32'h0, 2'd2, 1'b0);
        exp_beat(4'd4, 32'h0, 2'd2, 1'b1);
`else
        exp_beat(4'd4, 32'hFBFAF9F8, 2'd0, 1'b0);
        exp_beat(4'd4, 32'hFFFEFDFC, 2'd0, 1'b0);
        exp_beat(4'd4, 32'h0, 2'd3, 1'b0);
        exp_beat(4'd4, 32'h0, 2'd3, 1'b1);
`endif
        do_ar(4'd4, 32'hFF8, 4'd3, 3'd2, BURST_INCR);
        drain();

        // reset while beat 2 is on the bus
        exp_beat(4'd6, 32'h03020100, 2'd0, 1'b0);
        exp_beat(4'd6, 32'h07060504, 2'd0, 1'b0);
        exp_beat(4'd6, 32'h0B0A0908, 2'd0, 1'b0);
        exp_beat(4'd6, 32'h0F0E0D0C, 2'd0, 1'b1);
        do_ar(4'd6, 32'h000, 4'd3, 3'd2, BURST_INCR);
        @(posedge clk); #2;
        chk("beat2_before_reset", bus.rdata, 32'h07060504);
        reset = 1'b1;
        #1;
        chk("midrst_rvalid", bus.rvalid, 1'b0);
        chk("midrst_rlast", bus.rlast, 1'b0);
        chk("midrst_rdata", bus.rdata, 32'h0);
        chk("midrst_arready", bus.arready, 1'b0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("arready_after_midrst", bus.arready, 1'b1);
        chk("rvalid_after_midrst", bus.rvalid, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("no_residual_beats", bus.rvalid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
